// File: rtl/ws2812_frame_sched_if.sv
// Bus between the LED frame scheduler and its host/LED register file.
// The slave side is the scheduler; the master side is the host and memory.
interface ws2812_frame_sched_if #(
    parameter int AW = 1
);
    logic          start_i;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [23:0]   rd_data_i;
    logic          led_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        output start_i, rd_data_i,
        input  rd_en_o, rd_addr_o, led_o, busy_o, done_o
    );

    modport slave (
        input  start_i, rd_data_i,
        output rd_en_o, rd_addr_o, led_o, busy_o, done_o
    );
endinterface

// File: rtl/ws2812_frame_sched.sv
// WS2812B frame scheduler: walks LED indices, fetches each GRB word from
// a 1-cycle-latency register file, serializes it MSB first with
// programmable bit timing, then holds the line low for the latch gap.
module ws2812_frame_sched #(
    parameter int LED_CNT = 10,
    parameter int T0H     = 16,
    parameter int T1H     = 32,
    parameter int TBIT    = 50,
    parameter int TRESET  = 2400
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ws2812_frame_sched_if.slave  bus
);
    localparam int AW = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int PW = (TBIT > 1)    ? $clog2(TBIT)    : 1;
    localparam int LW = (TRESET > 1)  ? $clog2(TRESET)  : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

    state_t        state, state_d;
    logic [AW-1:0] idx;
    logic [PW-1:0] phase;
    logic [4:0]    bitc;
    logic [23:0]   sh;
    logic [LW-1:0] lat;
    logic          pending;
    logic          led_q;

    logic [PW-1:0] hi_len;
    logic          bit_end, lat_end, last_led, go;

    // High time of the bit currently on the wire (MSB of the shift register).
    assign hi_len   = sh[23] ? PW'(T1H) : PW'(T0H);
    assign bit_end  = (phase == PW'(TBIT - 1));
    assign lat_end  = (lat == LW'(TRESET - 1));
    assign last_led = (idx == AW'(LED_CNT - 1));
    // A fresh request or a coalesced one queued during the previous frame.
    assign go       = bus.start_i | pending;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic; the latch gap chains straight into FETCH when a
    // frame is requested so back-to-back frames have no idle cycle.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (go) state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD:  state_d = SEND;
            SEND:  if (bit_end && bitc == 5'd0) state_d = last_led ? LATCH : FETCH;
            LATCH: if (lat_end) state_d = go ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: index, bit/phase/latch counters, shift register, request
    // coalescing and the registered LED line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            phase   <= '0;
            bitc    <= '0;
            sh      <= '0;
            lat     <= '0;
            pending <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            // Any request while a frame is running collapses into one pending.
            if (state != IDLE && bus.start_i) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (go) begin
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                LOAD: begin
                    sh    <= bus.rd_data_i;
                    bitc  <= 5'd23;
                    phase <= '0;
                    led_q <= 1'b1;   // every bit starts high (T0H >= 1)
                end
                SEND: begin
                    if (!bit_end) begin
                        phase <= phase + PW'(1);
                        led_q <= (phase + PW'(1)) < hi_len;
                    end else if (bitc != 5'd0) begin
                        phase <= '0;
                        bitc  <= bitc - 5'd1;
                        sh    <= {sh[22:0], 1'b0};
                        led_q <= 1'b1;
                    end else begin
                        phase <= '0;
                        led_q <= 1'b0;
                        if (!last_led) idx <= idx + AW'(1);
                    end
                end
                LATCH: begin
                    if (lat_end) begin
                        lat <= '0;
                        if (go) begin
                            idx     <= '0;
                            pending <= 1'b0;
                        end
                    end else begin
                        lat <= lat + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; rd_addr_o is the held index.
    assign bus.rd_en_o   = (state == FETCH);
    assign bus.rd_addr_o = idx;
    assign bus.busy_o    = (state != IDLE);
    assign bus.done_o    = (state == LATCH) && lat_end;
    assign bus.led_o     = led_q;
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched with short timing parameters.
module tb_ws2812_frame_sched;
    localparam int T0H = 2, T1H = 4, TBIT = 6, TRESET = 10;
    localparam int NTR = 720;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ws2812_frame_sched_if #(.AW(1)) bus ();
    ws2812_frame_sched_if #(.AW(1)) bus2 ();

    ws2812_frame_sched #(.LED_CNT(2), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    ws2812_frame_sched #(.LED_CNT(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // LED register file models: one-cycle read latency.
    logic [23:0] mem [0:1];
    logic [23:0] mem_q, mem2_q, drv_data;
    logic        use_mem = 1'b1;
    always @(posedge clk) if (bus.rd_en_o) mem_q <= mem[bus.rd_addr_o];
    always @(posedge clk) if (bus2.rd_en_o) mem2_q <= 24'hF0F0F0;
    always_comb bus.rd_data_i = use_mem ? mem_q : drv_data;
    assign bus2.rd_data_i = mem2_q;

    int errors = 0;
    int checks = 0;

    logic       led_tr  [0:NTR];
    logic       done_tr [0:NTR];
    logic       rden_tr [0:NTR];
    logic       busy_tr [0:NTR];
    logic [0:0] addr_tr [0:NTR];

    // Rebuild the 24-bit word of the LED whose FETCH sits at cycle s; bit 24
    // flags any bit whose high pulse is neither T0H nor T1H contiguous cycles.
    function automatic logic [24:0] word_at(input int s);
        logic [24:0] r;
        r = '0;
        for (int k = 0; k < 24; k++) begin
            int lead, tot, base;
            bit run;
            lead = 0; tot = 0; run = 1'b1;
            base = s + 2 + k * TBIT;
            for (int p = 0; p < TBIT; p++) begin
                if (led_tr[base + p] === 1'b1) begin
                    tot++;
                    if (run) lead++;
                end else run = 1'b0;
            end
            if (lead == T1H && tot == T1H)      r[23 - k] = 1'b1;
            else if (lead == T0H && tot == T0H) r[23 - k] = 1'b0;
            else                                r[24] = 1'b1;
        end
        return r;
    endfunction

    // Pulse start at cycle 0, re-pulse at p0/p1, record n cycles of outputs.
    task automatic capture(input int n, input int p0, input int p1);
        bus.start_i = 1'b1;
        if (!use_mem) drv_data = 24'h5A5A5A;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            led_tr[i]  = bus.led_o;
            done_tr[i] = bus.done_o;
            rden_tr[i] = bus.rd_en_o;
            busy_tr[i] = bus.busy_o;
            addr_tr[i] = bus.rd_addr_o;
            bus.start_i = (i == p0 || i == p1);
            if (!use_mem)
                drv_data = (i == 2) ? 24'hA5C3F0 : (i == 148) ? 24'h13579B : (24'h5A5A5A ^ 24'(i));
        end
    endtask

    task automatic test_reset;
        int bad_led, bad_busy, bad_rden, ndone;
        bad_led = 0; bad_busy = 0; bad_rden = 0; ndone = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.led_o !== 1'b0) begin errors++; $display("FAIL rst_led got %b want 0", bus.led_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.rd_en_o !== 1'b0) begin errors++; $display("FAIL rst_rden got %b want 0", bus.rd_en_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.done_o); end
        checks++; if (bus.rd_addr_o !== 1'b0) begin errors++; $display("FAIL rst_addr got %h want 0", bus.rd_addr_o); end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.led_o !== 1'b0) bad_led++;
            if (bus.busy_o !== 1'b0) bad_busy++;
            if (bus.rd_en_o !== 1'b0) bad_rden++;
            if (bus.done_o !== 1'b0) ndone++;
        end
        checks++; if (bad_led != 0) begin errors++; $display("FAIL idle_led bad cycles %0d want 0", bad_led); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL idle_busy bad cycles %0d want 0", bad_busy); end
        checks++; if (bad_rden != 0) begin errors++; $display("FAIL idle_rden bad cycles %0d want 0", bad_rden); end
        checks++; if (ndone != 0) begin errors++; $display("FAIL idle_done pulses %0d want 0", ndone); end
    endtask

    task automatic test_frame;
        int first_done, ndone;
        mem[0] = 24'h800001; mem[1] = 24'h000000;
        capture(310, -1, -1);
        first_done = -1; ndone = 0;
        for (int i = 1; i <= 310; i++) if (done_tr[i] === 1'b1) begin
            ndone++;
            if (first_done < 0) first_done = i;
        end
        checks++; if (rden_tr[1] !== 1'b1 || addr_tr[1] !== 1'b0) begin errors++; $display("FAIL fetch0 got rden=%b addr=%h want 1/0", rden_tr[1], addr_tr[1]); end
        checks++; if (led_tr[2] !== 1'b0 || led_tr[3] !== 1'b1) begin errors++; $display("FAIL first_high got load=%b send=%b want 0/1", led_tr[2], led_tr[3]); end
        checks++; if (word_at(1) !== 25'h0800001) begin errors++; $display("FAIL led0_word got %h want 0800001", word_at(1)); end
        checks++; if (rden_tr[147] !== 1'b1 || addr_tr[147] !== 1'b1) begin errors++; $display("FAIL fetch1 got rden=%b addr=%h want 1/1", rden_tr[147], addr_tr[147]); end
        checks++; if ({led_tr[147], led_tr[148]} !== 2'b00) begin errors++; $display("FAIL gap_low got %b%b want 00", led_tr[147], led_tr[148]); end
        checks++; if (word_at(147) !== 25'h0000000) begin errors++; $display("FAIL led1_word got %h want 0000000", word_at(147)); end
        checks++; if (first_done != 302) begin errors++; $display("FAIL done_time got %0d want 302", first_done); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL done_count got %0d want 1", ndone); end
        checks++; if (busy_tr[302] !== 1'b1 || busy_tr[303] !== 1'b0) begin errors++; $display("FAIL busy_end got %b%b want 10", busy_tr[302], busy_tr[303]); end
        checks++; if (addr_tr[305] !== 1'b1) begin errors++; $display("FAIL addr_hold got %h want 1", addr_tr[305]); end
    endtask

    task automatic test_load_sample;
        use_mem = 1'b0;
        capture(310, -1, -1);
        use_mem = 1'b1;
        checks++; if (word_at(1) !== 25'h0A5C3F0) begin errors++; $display("FAIL load_word0 got %h want 0a5c3f0", word_at(1)); end
        checks++; if (word_at(147) !== 25'h013579B) begin errors++; $display("FAIL load_word1 got %h want 013579b", word_at(147)); end
    endtask

    task automatic test_back_to_back;
        int ndone, d0, d1, late_fetch;
        mem[0] = 24'h00FF00; mem[1] = 24'hC30001;
        capture(700, 50, 200);
        ndone = 0; d0 = -1; d1 = -1; late_fetch = 0;
        for (int i = 1; i <= 700; i++) begin
            if (done_tr[i] === 1'b1) begin
                if (ndone == 0) d0 = i; else if (ndone == 1) d1 = i;
                ndone++;
            end
            if (i >= 605 && rden_tr[i] === 1'b1) late_fetch++;
        end
        checks++; if (d0 != 302 || d1 != 604) begin errors++; $display("FAIL pend_done got %0d,%0d want 302,604", d0, d1); end
        checks++; if (ndone != 2) begin errors++; $display("FAIL pend_count got %0d want 2", ndone); end
        checks++; if (rden_tr[303] !== 1'b1 || addr_tr[303] !== 1'b0) begin errors++; $display("FAIL pend_fetch got rden=%b addr=%h want 1/0", rden_tr[303], addr_tr[303]); end
        checks++; if (word_at(303 + 146) !== 25'h0C30001) begin errors++; $display("FAIL pend_word got %h want 0c30001", word_at(449)); end
        checks++; if (late_fetch != 0 || busy_tr[605] !== 1'b0) begin errors++; $display("FAIL pend_extra got fetches=%0d busy=%b want 0/0", late_fetch, busy_tr[605]); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        mem[0] = 24'h800001; mem[1] = 24'h000400;
        bus.start_i = 1'b1;
        for (int i = 1; i <= 228; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        checks++; if (bus.led_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_pre got led=%b busy=%b want 1/1", bus.led_o, bus.busy_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.led_o !== 1'b0) begin errors++; $display("FAIL mid_led got %b want 0", bus.led_o); end
        checks++; if (bus.busy_o !== 1'b0 || bus.rd_en_o !== 1'b0) begin errors++; $display("FAIL mid_busy got busy=%b rden=%b want 0/0", bus.busy_o, bus.rd_en_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL mid_nodone got %0d active cycles want 0", ndone); end
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++; if (bus.rd_en_o !== 1'b1 || bus.rd_addr_o !== 1'b0) begin errors++; $display("FAIL mid_restart got rden=%b addr=%h want 1/0", bus.rd_en_o, bus.rd_addr_o); end
        repeat (310) @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mid_finish got busy=%b want 0", bus.busy_o); end
    endtask

    task automatic test_single_led_hold;
        int dt [0:3];
        int nd;
        bit f157, f313, busy_gap;
        nd = 0; f157 = 0; f313 = 0; busy_gap = 0;
        for (int k = 0; k < 4; k++) dt[k] = -1;
        bus2.start_i = 1'b1;
        for (int i = 1; i <= 480; i++) begin
            @(negedge clk);
            if (bus2.done_o === 1'b1) begin
                if (nd < 4) dt[nd] = i;
                nd++;
            end
            if (i == 157) f157 = (bus2.rd_en_o === 1'b1);
            if (i == 313) f313 = (bus2.rd_en_o === 1'b1);
            if (bus2.busy_o !== 1'b1) busy_gap = 1'b1;
        end
        bus2.start_i = 1'b0;
        checks++; if (dt[0] != 156 || dt[1] != 312 || dt[2] != 468) begin errors++; $display("FAIL hold_done got %0d,%0d,%0d want 156,312,468", dt[0], dt[1], dt[2]); end
        checks++; if (nd != 3) begin errors++; $display("FAIL hold_count got %0d want 3", nd); end
        checks++; if (!f157 || !f313) begin errors++; $display("FAIL hold_fetch got %b%b want 11", f157, f313); end
        checks++; if (busy_gap) begin errors++; $display("FAIL hold_busy got gap=1 want 0"); end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus2.start_i = 1'b0;
        drv_data = 24'h0;
        mem[0] = 24'h0; mem[1] = 24'h0;
        test_reset();
        test_frame();
        repeat (3) @(negedge clk);
        test_load_sample();
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_reset_mid();
        repeat (3) @(negedge clk);
        test_single_led_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
